// File: rtl/fwd_pkg.sv
// Shared types for the forward-stage batch sequencer: FSM state encoding and weight/bias word width.
package fwd_pkg;

  typedef logic [2:0] fwd_seq_state_t;

  localparam fwd_seq_state_t ST_IDLE  = 3'd0;
  localparam fwd_seq_state_t ST_LOAD  = 3'd1;
  localparam fwd_seq_state_t ST_RUN   = 3'd2;
  localparam fwd_seq_state_t ST_DRAIN = 3'd3;
  localparam fwd_seq_state_t ST_DONE  = 3'd4;

  // Packed weight matrix (NC x NP words) followed by NC bias words.
  function automatic int fwd_ww(input int np, input int nc, input int wf);
    return nc * np * wf + nc * wf;
  endfunction

endpackage

// File: rtl/fwd_credit_ctr.sv
// Per-channel issue counter with an outstanding-sample credit check against the completion count.
module fwd_credit_ctr #(
  parameter int WB     = 8,
  parameter int MAXOUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [WB-1:0] batch,
  input  logic [WB-1:0] cnt_c,
  output logic [WB-1:0] cnt_nxt,
  output logic          below,
  output logic          credit
);

  localparam logic [WB-1:0] MAXOUT_W = WB'(MAXOUT);

  logic [WB-1:0] cnt;
  logic [WB-1:0] outstanding;

  always_comb begin
    cnt_nxt     = cnt + {{(WB-1){1'b0}}, inc};
    // Wrapping difference is exact because completions never pass issues.
    outstanding = cnt - cnt_c;
    below       = cnt < batch;
    credit      = outstanding < MAXOUT_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/forward_sequencer.sv
// Batch controller: loads one weight/bias word, replays it per sample and gates the state stream under a credit limit.
// Optional FORWARD_SEQ_STALL_CNT_EN adds oStallCnt, a saturating count of credit-blocked RUN cycles.
module forward_sequencer
  import fwd_pkg::*;
#(
  parameter int NP     = 7,
  parameter int NC     = 11,
  parameter int WF     = 5,
  parameter int WB     = 8,
  parameter int MAXOUT = 4,
  localparam int WW    = fwd_ww(NP, NC, WF)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [WB-1:0]    iBatch,
  output logic             oBusy,
  output logic             oDone,
  input  logic             iValid_AS_WeightBias,
  output logic             oReady_AS_WeightBias,
  input  logic [WW-1:0]    iData_AS_WeightBias,
  output logic             oValid_BM_WeightBias,
  input  logic             iReady_BM_WeightBias,
  output logic [WW-1:0]    oData_BM_WeightBias,
  input  logic             iValid_AS_State0,
  output logic             oReady_AS_State0,
  input  logic [NP*WF-1:0] iData_AS_State0,
  output logic             oValid_BM_State0,
  input  logic             iReady_BM_State0,
  output logic [NP*WF-1:0] oData_BM_State0,
  input  logic             iValid_Mon_Accum,
  input  logic             iReady_Mon_Accum
`ifdef FORWARD_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]      oStallCnt
`endif
);

  fwd_seq_state_t state, state_nxt;

  logic [WB-1:0] batch_r;
  logic [WB-1:0] cnt_c, cnt_c_nxt;
  logic [WB-1:0] cnt_w_nxt, cnt_s_nxt;
  logic [WW-1:0] wb_r;

  logic in_run, in_drain, start_fire, wb_fire;
  logic w_fire, s_fire, c_fire;
  logic w_below, w_credit, s_below, s_credit, w_gate, s_gate;

  always_comb begin
    in_run     = (state == ST_RUN);
    in_drain   = (state == ST_DRAIN);
    start_fire = (state == ST_IDLE) && iStart;

    oBusy = (state != ST_IDLE);
    oDone = (state == ST_DONE);

    oReady_AS_WeightBias = (state == ST_LOAD);
    wb_fire              = oReady_AS_WeightBias && iValid_AS_WeightBias;

    // Gates look only at registered counts so a raised valid cannot be withdrawn.
    w_gate = w_below && w_credit;
    s_gate = s_below && s_credit;

    oValid_BM_WeightBias = in_run && w_gate;
    oData_BM_WeightBias  = wb_r;
    w_fire               = oValid_BM_WeightBias && iReady_BM_WeightBias;

    oValid_BM_State0 = in_run && s_gate && iValid_AS_State0;
    oReady_AS_State0 = in_run && s_gate && iReady_BM_State0;
    oData_BM_State0  = iData_AS_State0;
    s_fire           = oValid_BM_State0 && iReady_BM_State0;

    c_fire    = (in_run || in_drain) && iValid_Mon_Accum && iReady_Mon_Accum;
    cnt_c_nxt = cnt_c + {{(WB-1){1'b0}}, c_fire};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (iStart) state_nxt = (iBatch == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:  if (wb_fire) state_nxt = ST_RUN;
      ST_RUN:   if (cnt_w_nxt == batch_r && cnt_s_nxt == batch_r) state_nxt = ST_DRAIN;
      ST_DRAIN: if (cnt_c_nxt == batch_r) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state   <= ST_IDLE;
      batch_r <= '0;
      cnt_c   <= '0;
      wb_r    <= '0;
    end else begin
      state <= state_nxt;
      if (start_fire) begin
        batch_r <= iBatch;
        cnt_c   <= '0;
      end else begin
        cnt_c <= cnt_c_nxt;
      end
      if (wb_fire) wb_r <= iData_AS_WeightBias;
    end
  end

  fwd_credit_ctr #(.WB(WB), .MAXOUT(MAXOUT)) u_ctr_w (
    .clk     (iCLK),
    .rst_n   (iRST),
    .clr     (start_fire),
    .inc     (w_fire),
    .batch   (batch_r),
    .cnt_c   (cnt_c),
    .cnt_nxt (cnt_w_nxt),
    .below   (w_below),
    .credit  (w_credit)
  );

  fwd_credit_ctr #(.WB(WB), .MAXOUT(MAXOUT)) u_ctr_s (
    .clk     (iCLK),
    .rst_n   (iRST),
    .clr     (start_fire),
    .inc     (s_fire),
    .batch   (batch_r),
    .cnt_c   (cnt_c),
    .cnt_nxt (cnt_s_nxt),
    .below   (s_below),
    .credit  (s_credit)
  );

`ifdef FORWARD_SEQ_STALL_CNT_EN
  logic stall_hit;

  always_comb begin
    stall_hit = in_run && ((w_below && !w_credit) || (s_below && !s_credit));
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oStallCnt <= '0;
    end else if (start_fire) begin
      oStallCnt <= '0;
    end else if (stall_hit && oStallCnt != 32'hFFFF_FFFF) begin
      oStallCnt <= oStallCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forward_sequencer.sv
// Scoreboard bench for forward_sequencer: expected weight/state beats are queued at stimulus time and popped on each output fire.
module tb_forward_sequencer;
  import fwd_pkg::*;

  localparam int NP = 7, NC = 11, WF = 5, WB = 8, MAXOUT = 2;
  localparam int WW = fwd_ww(NP, NC, WF);
  localparam int SW = NP * WF;

  logic          clk, rst_n;
  logic          iStart, oBusy, oDone;
  logic [WB-1:0] iBatch;
  logic          iValid_AS_WeightBias, oReady_AS_WeightBias;
  logic [WW-1:0] iData_AS_WeightBias;
  logic          oValid_BM_WeightBias, iReady_BM_WeightBias;
  logic [WW-1:0] oData_BM_WeightBias;
  logic          iValid_AS_State0, oReady_AS_State0;
  logic [SW-1:0] iData_AS_State0;
  logic          oValid_BM_State0, iReady_BM_State0;
  logic [SW-1:0] oData_BM_State0;
  logic          iValid_Mon_Accum, iReady_Mon_Accum;
`ifdef FORWARD_SEQ_STALL_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   st0;
`endif

  forward_sequencer #(.NP(NP), .NC(NC), .WF(WF), .WB(WB), .MAXOUT(MAXOUT)) dut (
    .iCLK(clk), .iRST(rst_n), .iStart(iStart), .iBatch(iBatch), .oBusy(oBusy), .oDone(oDone),
    .iValid_AS_WeightBias(iValid_AS_WeightBias), .oReady_AS_WeightBias(oReady_AS_WeightBias),
    .iData_AS_WeightBias(iData_AS_WeightBias),
    .oValid_BM_WeightBias(oValid_BM_WeightBias), .iReady_BM_WeightBias(iReady_BM_WeightBias),
    .oData_BM_WeightBias(oData_BM_WeightBias),
    .iValid_AS_State0(iValid_AS_State0), .oReady_AS_State0(oReady_AS_State0), .iData_AS_State0(iData_AS_State0),
    .oValid_BM_State0(oValid_BM_State0), .iReady_BM_State0(iReady_BM_State0), .oData_BM_State0(oData_BM_State0),
    .iValid_Mon_Accum(iValid_Mon_Accum), .iReady_Mon_Accum(iReady_Mon_Accum)
`ifdef FORWARD_SEQ_STALL_CNT_EN
    , .oStallCnt(stall_cnt)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int checks = 0, errors = 0;
  int w_fires = 0, s_fires = 0, done_cnt = 0;
  int w0, s0, d0;
  logic [WW-1:0] exp_w[$];
  logic [SW-1:0] exp_s[$];
  logic [WW-1:0] wcur;
  logic          s_fire_smp = 0;
  logic [1:0]    pipe = 0;
  logic          mon_auto = 0, mon_pulse = 0;
  int            s_idx = 0, s_total = 0;
  logic [31:0]   s_base = 0;

  function automatic logic [SW-1:0] spat(input logic [31:0] base, input int i);
    logic [31:0] v;
    v = base + 32'(i) * 32'h0101_0101;
    return SW'(v);
  endfunction

  function automatic logic [WW-1:0] wpat(input logic [31:0] seed);
    logic [14*32-1:0] t;
    t = {14{seed}};
    return t[WW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: advance the state source and the emulated accumulator two cycles behind it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (s_fire_smp) s_idx++;
    pipe = {pipe[0], s_fire_smp};
    iValid_Mon_Accum = mon_auto ? pipe[1] : mon_pulse;
    mon_pulse = 0;
    iValid_AS_State0 = (s_idx < s_total);
    iData_AS_State0  = spat(s_base, s_idx);
  endtask

  task automatic start_batch(input int b);
    tick();
    iStart = 1;
    iBatch = WB'(b);
    tick();
    iStart = 0;
    iBatch = '0;
  endtask

  task automatic load_batch(input logic [31:0] wseed, input logic [31:0] sbase, input int n);
    wcur = wpat(wseed);
    iData_AS_WeightBias = wcur;
    s_base = sbase;
    s_idx = 0;
    s_total = n;
    for (int i = 0; i < n; i++) begin
      exp_w.push_back(wcur);
      exp_s.push_back(spat(sbase, i));
    end
    w0 = w_fires;
    s0 = s_fires;
    d0 = done_cnt;
  endtask

  task automatic wait_done(input int bound, input bit chk_prev);
    bit found, prev, cur;
    found = 0;
    prev = 0;
    for (int i = 0; i < bound && !found; i++) begin
      tick();
      @(negedge clk);
      cur = iValid_Mon_Accum && iReady_Mon_Accum;
      if (oDone) begin
        found = 1;
        if (chk_prev) check("done_after_last_cmpl", prev, 1);
      end
      prev = cur;
    end
    check("done_seen", found, 1);
    tick();
    @(negedge clk);
    check("busy_low_after_done", oBusy, 0);
    check("done_one_cycle", oDone, 0);
  endtask

  task automatic check_batch(input string tag, input int n);
    check({tag, "_wfires"}, w_fires - w0, n);
    check({tag, "_sfires"}, s_fires - s0, n);
    check({tag, "_dones"}, done_cnt - d0, 1);
    check({tag, "_wq_empty"}, exp_w.size(), 0);
    check({tag, "_sq_empty"}, exp_s.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every output fire.
  initial begin
    logic [WW-1:0] ew;
    logic [SW-1:0] es;
    forever begin
      @(negedge clk);
      s_fire_smp = oValid_BM_State0 && iReady_BM_State0;
      if (rst_n) begin
        if (oValid_BM_WeightBias && iReady_BM_WeightBias) begin
          w_fires++;
          checks++;
          if (exp_w.size() == 0) begin
            errors++;
            $display("FAIL w_fire: got a weight fire, expected none");
          end else begin
            ew = exp_w.pop_front();
            if (oData_BM_WeightBias !== ew) begin
              errors++;
              $display("FAIL w_data: got %0h expected %0h", oData_BM_WeightBias, ew);
            end
          end
        end
        if (s_fire_smp) begin
          s_fires++;
          checks++;
          if (exp_s.size() == 0) begin
            errors++;
            $display("FAIL s_fire: got a state fire, expected none");
          end else begin
            es = exp_s.pop_front();
            if (oData_BM_State0 !== es) begin
              errors++;
              $display("FAIL s_data: got %0h expected %0h", oData_BM_State0, es);
            end
          end
        end
        if (oDone) done_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1;
    iStart = 0; iBatch = '0;
    iValid_AS_WeightBias = 1; iData_AS_WeightBias = '0; iReady_BM_WeightBias = 1;
    iValid_AS_State0 = 0; iData_AS_State0 = '0; iReady_BM_State0 = 1;
    iValid_Mon_Accum = 0; iReady_Mon_Accum = 1;
    #2 rst_n = 0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_wb_rdy", oReady_AS_WeightBias, 0);
    check("rst_w_vld", oValid_BM_WeightBias, 0);
    check("rst_s_vld", oValid_BM_State0, 0);
    check("rst_s_rdy", oReady_AS_State0, 0);
    check("rst_rwb", |oData_BM_WeightBias, 0);
    tick();
    rst_n = 1;
    tick();

    // Batch 3, accumulator answers two cycles after each state beat.
    load_batch(32'h1234_5678, 32'hA000_0000, 3);
    mon_auto = 1;
    start_batch(3);
    @(negedge clk);
    check("t1_load_rdy", oReady_AS_WeightBias, 1);
    check("t1_load_wvld", oValid_BM_WeightBias, 0);
    check("t1_load_busy", oBusy, 1);
    tick();
    iData_AS_WeightBias = wpat(32'hDEAD_BEEF);
    @(negedge clk);
    check("t1_first_wvld", oValid_BM_WeightBias, 1);
    wait_done(60, 1);
    repeat (2) tick();
    check_batch("t1", 3);

    // Batch 6 with completions withheld: credit stops both channels at MAXOUT.
    mon_auto = 0;
    load_batch(32'h0F0F_A5A5, 32'hB000_0000, 6);
    start_batch(6);
    repeat (20) tick();
    check("t2_w_held", w_fires - w0, 2);
    check("t2_s_held", s_fires - s0, 2);
    @(negedge clk);
    check("t2_wvld_low", oValid_BM_WeightBias, 0);
    check("t2_svld_low", oValid_BM_State0, 0);
    check("t2_srdy_low", oReady_AS_State0, 0);
    mon_pulse = 1;
    repeat (8) tick();
    check("t2_w_one_more", w_fires - w0, 3);
    check("t2_s_one_more", s_fires - s0, 3);
    for (int k = 0; k < 4; k++) begin
      mon_pulse = 1;
      repeat (4) tick();
    end
    mon_pulse = 1;
    wait_done(20, 1);
    repeat (2) tick();
    check_batch("t2", 6);

    // Empty batch goes straight to DONE without touching the weight source.
    d0 = done_cnt;
    tick();
    iStart = 1;
    iBatch = '0;
    tick();
    iStart = 0;
    @(negedge clk);
    check("t3_done", oDone, 1);
    check("t3_no_load", oReady_AS_WeightBias, 0);
    tick();
    @(negedge clk);
    check("t3_done_drop", oDone, 0);
    check("t3_idle", oBusy, 0);
    check("t3_no_load2", oReady_AS_WeightBias, 0);
    tick();
    check("t3_dones", done_cnt - d0, 1);

    // Stage state input stalled: upstream ready stays low, weights still credit-limited.
    iReady_BM_State0 = 0;
    mon_auto = 1;
    load_batch(32'h5555_AAAA, 32'hC000_0000, 5);
    start_batch(5);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_srdy_low", oReady_AS_State0, 0);
      tick();
    end
    check("t4_w_credit", w_fires - w0, 2);
    check("t4_s_none", s_fires - s0, 0);
    iReady_BM_State0 = 1;
    wait_done(80, 1);
    repeat (2) tick();
    check_batch("t4", 5);

`ifdef FORWARD_SEQ_STALL_CNT_EN
    // Both channels blocked every RUN cycle once MAXOUT samples are out.
    mon_auto = 0;
    load_batch(32'h3C3C_0101, 32'hF000_0000, 4);
    start_batch(4);
    @(negedge clk);
    check("t6_stall_clr", stall_cnt, 0);
    repeat (6) tick();
    st0 = stall_cnt;
    repeat (10) tick();
    check("t6_stall_rate", stall_cnt - st0, 10);
    for (int k = 0; k < 3; k++) begin
      mon_pulse = 1;
      repeat (4) tick();
    end
    mon_pulse = 1;
    wait_done(20, 1);
    st0 = stall_cnt;
    repeat (5) tick();
    check("t6_stall_idle", stall_cnt - st0, 0);
    check_batch("t6", 4);
`endif

    // Asynchronous reset after two of five samples, then a clean batch of one.
    mon_auto = 0;
    load_batch(32'h7777_0001, 32'hD000_0000, 5);
    start_batch(5);
    for (int i = 0; i < 20 && (s_fires - s0) < 2; i++) tick();
    check("t5_two_issued", s_fires - s0, 2);
    repeat (2) tick();
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    check("t5_rst_busy", oBusy, 0);
    check("t5_rst_done", oDone, 0);
    check("t5_rst_wvld", oValid_BM_WeightBias, 0);
    check("t5_rst_svld", oValid_BM_State0, 0);
    check("t5_rst_srdy", oReady_AS_State0, 0);
    check("t5_rst_wbrdy", oReady_AS_WeightBias, 0);
    check("t5_rst_rwb", |oData_BM_WeightBias, 0);
    exp_w.delete();
    exp_s.delete();
    s_total = 0;
    s_idx = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    load_batch(32'h0BAD_F00D, 32'hE000_0000, 1);
    mon_auto = 1;
    start_batch(1);
    wait_done(40, 1);
    repeat (2) tick();
    check_batch("t5", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
